// File: rtl/hdmi_word_align.sv
// Per-lane TMDS word aligner: searches the 10 bit rotations for runs of control tokens and emits aligned symbols.
// Optional manual rotation override is enabled with `define HDMI_ALIGN_MANUAL_EN.
module hdmi_word_align #(
  parameter int unsigned LOCK_RUN = 8,
  parameter int unsigned LGSEARCH = 16,
  parameter int unsigned LGLOSS   = 22
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [9:0] i_word,
`ifdef HDMI_ALIGN_MANUAL_EN
  input  logic       i_manual,
  input  logic [3:0] i_manual_shift,
`endif
  output logic [9:0] o_word,
  output logic       o_ctrl,
  output logic [1:0] o_ctrl_code,
  output logic       o_locked,
  output logic [3:0] o_shift
);

  localparam int unsigned RW = $clog2(LOCK_RUN + 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [9:0]          prev_word;
  logic [RW-1:0]       run_cnt;
  logic [LGSEARCH-1:0] dwell_cnt;
  logic [LGLOSS-1:0]   loss_cnt;

  logic [19:0]   cat_shifted_c;
  logic [9:0]    window_c;
  logic          win_tok_c;
  logic [1:0]    win_code_c;
  logic [RW-1:0] run_inc_c;
  logic          run_hit_c;
  logic          run_sat_c;
  logic [3:0]    shift_adv_c;
  logic          manual_c;
  logic [3:0]    manual_shift_c;

`ifdef HDMI_ALIGN_MANUAL_EN
  always_comb begin
    manual_c       = i_manual;
    manual_shift_c = (i_manual_shift > 4'd9) ? 4'd0 : i_manual_shift;
  end
`else
  always_comb begin
    manual_c       = 1'b0;
    manual_shift_c = 4'd0;
  end
`endif

  // Window = {previous, current} starting o_shift bits into the previous word
  always_comb begin
    cat_shifted_c = {prev_word, i_word} << o_shift;
    window_c      = cat_shifted_c[19:10];
  end

  always_comb begin
    win_tok_c  = 1'b1;
    win_code_c = 2'd0;
    case (window_c)
      10'b1101010100: win_code_c = 2'd0;
      10'b0010101011: win_code_c = 2'd1;
      10'b0101010100: win_code_c = 2'd2;
      10'b1010101011: win_code_c = 2'd3;
      default:        win_tok_c  = 1'b0;
    endcase
  end

  always_comb begin
    run_sat_c   = win_tok_c && (run_cnt == RW'(LOCK_RUN));
    run_hit_c   = win_tok_c && (run_cnt == RW'(LOCK_RUN - 1));
    run_inc_c   = (run_cnt == RW'(LOCK_RUN)) ? run_cnt : RW'(run_cnt + RW'(1));
    shift_adv_c = (o_shift == 4'd9) ? 4'd0 : 4'(o_shift + 4'd1);
  end

  // Alignment FSM; any rotation change also restarts the token run
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_SEARCH;
      prev_word   <= '0;
      run_cnt     <= '0;
      dwell_cnt   <= '0;
      loss_cnt    <= '0;
      o_word      <= '0;
      o_ctrl      <= 1'b0;
      o_ctrl_code <= 2'd0;
      o_locked    <= 1'b0;
      o_shift     <= 4'd0;
    end else begin
      prev_word   <= i_word;
      o_word      <= window_c;
      o_ctrl      <= win_tok_c;
      o_ctrl_code <= win_code_c;
      run_cnt     <= win_tok_c ? run_inc_c : '0;
      if (manual_c) begin
        state     <= ST_SEARCH;
        o_locked  <= 1'b0;
        o_shift   <= manual_shift_c;
        run_cnt   <= '0;
        dwell_cnt <= '0;
        loss_cnt  <= '0;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (run_hit_c) begin
              state    <= ST_LOCKED;
              o_locked <= 1'b1;
              loss_cnt <= '0;
            end else if (&dwell_cnt) begin
              o_shift   <= shift_adv_c;
              dwell_cnt <= '0;
              run_cnt   <= '0;
            end else begin
              dwell_cnt <= LGSEARCH'(dwell_cnt + LGSEARCH'(1));
            end
          end
          ST_LOCKED: begin
            if (run_hit_c || run_sat_c) begin
              loss_cnt <= '0;
            end else if (&loss_cnt) begin
              state     <= ST_SEARCH;
              o_locked  <= 1'b0;
              o_shift   <= shift_adv_c;
              run_cnt   <= '0;
              dwell_cnt <= '0;
            end else begin
              loss_cnt <= LGLOSS'(loss_cnt + LGLOSS'(1));
            end
          end
          default: begin
            state    <= ST_SEARCH;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_word_align.sv
// Bench for hdmi_word_align: bit-stream stimulus at chosen offsets, checked every cycle against a reference model.
module tb_hdmi_word_align;

  localparam int unsigned LOCK_RUN = 4;
  localparam int unsigned LGSEARCH = 4;
  localparam int unsigned LGLOSS   = 6;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b1;
  logic [9:0] i_word = '0;
  logic       man = 1'b0;
  logic [3:0] man_shift = '0;
  logic [9:0] o_word;
  logic       o_ctrl;
  logic [1:0] o_ctrl_code;
  logic       o_locked;
  logic [3:0] o_shift;

  hdmi_word_align #(
    .LOCK_RUN(LOCK_RUN),
    .LGSEARCH(LGSEARCH),
    .LGLOSS  (LGLOSS)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_word        (i_word),
`ifdef HDMI_ALIGN_MANUAL_EN
    .i_manual      (man),
    .i_manual_shift(man_shift),
`endif
    .o_word        (o_word),
    .o_ctrl        (o_ctrl),
    .o_ctrl_code   (o_ctrl_code),
    .o_locked      (o_locked),
    .o_shift       (o_shift)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  int toks[4] = '{'h354, 'h0AB, 'h154, 'h2AB};

  int m_prev, m_shift, m_locked, m_run, m_dwell, m_loss, m_word, m_ctrl, m_code;

  bit bq[$];

  function automatic int tok_idx(input int v);
    for (int i = 0; i < 4; i++) if (toks[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_shift = 0; m_locked = 0; m_run = 0; m_dwell = 0; m_loss = 0;
    m_word = 0; m_ctrl = 0; m_code = 0;
  endtask

  // Next-cycle expectation from the alignment rules, plain integer arithmetic
  task automatic model_step(input int w);
    int win, ti, nrun;
    win = (((m_prev << 10) | w) >> (10 - m_shift)) & 'h3FF;
    ti = tok_idx(win);
    m_word = win;
    m_ctrl = (ti >= 0) ? 1 : 0;
    m_code = (ti >= 0) ? ti : 0;
    nrun = (ti < 0) ? 0 : ((m_run + 1 > int'(LOCK_RUN)) ? int'(LOCK_RUN) : m_run + 1);
    if (man) begin
      m_shift = (man_shift > 9) ? 0 : int'(man_shift);
      m_locked = 0; nrun = 0; m_dwell = 0; m_loss = 0;
    end else if (m_locked == 0) begin
      if (ti >= 0 && m_run == int'(LOCK_RUN) - 1) begin
        m_locked = 1; m_loss = 0;
      end else if (m_dwell == (1 << LGSEARCH) - 1) begin
        m_shift = (m_shift + 1) % 10; m_dwell = 0; nrun = 0;
      end else begin
        m_dwell++;
      end
    end else begin
      if (nrun == int'(LOCK_RUN)) begin
        m_loss = 0;
      end else if (m_loss == (1 << LGLOSS) - 1) begin
        m_locked = 0; m_shift = (m_shift + 1) % 10; m_dwell = 0; nrun = 0;
      end else begin
        m_loss++;
      end
    end
    m_run = nrun;
    m_prev = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_all();
    chk("o_word", 32'(o_word), m_word);
    chk("o_ctrl", 32'(o_ctrl), m_ctrl);
    chk("o_ctrl_code", 32'(o_ctrl_code), m_code);
    chk("o_locked", 32'(o_locked), m_locked);
    chk("o_shift", 32'(o_shift), m_shift);
  endtask

  task automatic step(input logic [9:0] w);
    i_word = w;
    @(posedge i_clk);
    model_step(int'(w));
    #1;
    check_all();
  endtask

  task automatic new_stream(input int k);
    bq.delete();
    for (int i = 0; i < k; i++) bq.push_back(1'($urandom));
  endtask

  // Serialize one symbol (bit 9 first) and deliver the next 10 received bits
  task automatic send(input logic [9:0] s);
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
    for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
    step(w);
  endtask

  task automatic do_reset();
    #2;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      i_word = 10'($urandom);
      @(posedge i_clk);
      #1;
      check_all();
    end
    i_reset_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset with random input, then aligned 1101010100 stream
    do_reset();
    new_stream(0);
    repeat (12) send(10'h354);
    chk("aligned_locked", 32'(o_locked), 1);
    chk("aligned_shift", 32'(o_shift), 0);
    chk("aligned_code", 32'(o_ctrl_code), 0);

    // Runs of 3 tokens never refresh lock
    repeat (25) begin
      repeat (3) send(10'h354);
      send(10'h1F0);
    end
    chk("run3_dropped", 32'(o_locked), 0);

    // Asynchronous reset while locked
    do_reset();
    new_stream(0);
    repeat (8) send(10'h354);
    chk("pre_rst_locked", 32'(o_locked), 1);
    do_reset();

    // Offset 3 with code-01 token
    new_stream(3);
    repeat (60) send(10'h0AB);
    chk("off3_locked", 32'(o_locked), 1);
    chk("off3_shift", 32'(o_shift), 3);
    chk("off3_word", 32'(o_word), 'h0AB);
    chk("off3_code", 32'(o_ctrl_code), 1);

    // Rotation 9, then realign to 0 after loss
    do_reset();
    new_stream(9);
    repeat (160) send(10'h354);
    chk("off9_locked", 32'(o_locked), 1);
    chk("off9_shift", 32'(o_shift), 9);
    new_stream(0);
    repeat (80) send(10'h354);
    chk("wrap_locked", 32'(o_locked), 1);
    chk("wrap_shift", 32'(o_shift), 0);

    // Random token/data mixes at random offsets
    for (int t = 0; t < 4; t++) begin
      int thr;
      thr = 5 + t % 3;
      do_reset();
      new_stream(int'($urandom % 10));
      repeat (250) begin
        if (($urandom % 8) < thr) send(10'(toks[$urandom % 4]));
        else send(10'($urandom));
      end
    end

`ifdef HDMI_ALIGN_MANUAL_EN
    do_reset();
    new_stream(5);
    man = 1'b1;
    man_shift = 4'd12;
    repeat (6) send(10'h354);
    chk("man12_shift", 32'(o_shift), 0);
    chk("man12_locked", 32'(o_locked), 0);
    man_shift = 4'd5;
    repeat (6) send(10'h354);
    chk("man5_shift", 32'(o_shift), 5);
    chk("man5_locked", 32'(o_locked), 0);
    man = 1'b0;
    repeat (4) send(10'h354);
    chk("man_release_locked", 32'(o_locked), 1);
    chk("man_release_shift", 32'(o_shift), 5);
    repeat (10) send(10'h154);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
